// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider
// ----------------------------------------------------------------------------
// Iterative restoring divider. It computes one quotient bit per clock and
// sits beside the 64x64->128 multiplier under the ALU. The ALU control FSM
// pulses start and then waits for done.
//
// Timing (start sampled at edge 0):
//   - normal divide : busy in cycles 1..WIDTH, done pulse in cycle WIDTH+1
//   - divide by zero: done pulse in cycle 1, busy never asserted
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   request, sampled only in IDLE
//   dividend    in   [WIDTH] numerator, captured on accepted start
//   divisor     in   [WIDTH] denominator, captured on accepted start
//   is_signed   in   two's-complement select, captured on accepted start
//                    (only honoured when SEQ_DIVIDER_SIGNED_EN is defined)
//   busy        out  high while the iteration is running
//   done        out  one-cycle pulse when the results are updated
//   quotient    out  [WIDTH] result quotient, held until the next result
//   remainder   out  [WIDTH] result remainder, held until the next result
//   div_by_zero out  set together with done when the divisor was zero
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   Defined     : is_signed=1 selects truncating two's-complement division.
//                 Operands become magnitudes on capture, and signs are
//                 restored when the result is written.
//   Not defined : all division is unsigned and is_signed is ignored.
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Control and result registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    // ------------------------------------------------------------------------
    // Working datapath registers. These are not reset: every use of them is
    // preceded by a load on an accepted start.
    // ------------------------------------------------------------------------
    // The partial remainder always stays below the divisor after the restore
    // step, so WIDTH bits are enough to hold it between iterations. Only the
    // shifted value needs the extra bit.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;

    // ------------------------------------------------------------------------
    // Operand conditioning and result fix-up
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // One restoring iteration
    logic [WIDTH:0]   w_sh_r;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_r_nx;
    logic [WIDTH-1:0] w_q_nx;

    // Shift the {R,Q} pair left by one. The next dividend bit enters R.
    assign w_sh_r = {r_rem, r_q[WIDTH-1]};

    // The trial subtraction succeeds when the shifted remainder is at least
    // the divisor. The difference is then below the divisor, so its low
    // WIDTH bits are exact.
    assign w_ge   = (w_sh_r >= {1'b0, r_div});
    assign w_diff = w_sh_r[WIDTH-1:0] - r_div;
    assign w_r_nx = w_ge ? w_diff : w_sh_r[WIDTH-1:0];
    assign w_q_nx = {r_q[WIDTH-2:0], w_ge};

`ifdef SEQ_DIVIDER_SIGNED_EN
    function automatic logic [WIDTH-1:0] f_negate(input logic [WIDTH-1:0] v);
        return -v;
    endfunction

    logic w_neg_a;
    logic w_neg_b;
    logic r_neg_q;
    logic r_neg_r;

    assign w_neg_a = is_signed & dividend[WIDTH-1];
    assign w_neg_b = is_signed & divisor[WIDTH-1];

    // The magnitude of MIN is 2^(WIDTH-1). That value is still representable
    // as an unsigned magnitude, so MIN/-1 produces quotient MIN with no
    // special case.
    assign w_mag_a = w_neg_a ? f_negate(dividend) : dividend;
    assign w_mag_b = w_neg_b ? f_negate(divisor)  : divisor;

    // Truncating division: the quotient sign is the XOR of the operand
    // signs, and the remainder takes the sign of the dividend.
    assign w_q_fix = r_neg_q ? f_negate(w_q_nx) : w_q_nx;
    assign w_r_fix = r_neg_r ? f_negate(w_r_nx) : w_r_nx;

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
        end
    end
`else
    // Unsigned only. is_signed stays on the port list so that the interface
    // is the same in both builds.
    logic w_unused;
    assign w_unused = is_signed;

    assign w_mag_a = dividend;
    assign w_mag_b = divisor;
    assign w_q_fix = w_q_nx;
    assign w_r_fix = w_r_nx;
`endif

    // ------------------------------------------------------------------------
    // Working register load (capture) and iteration
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            r_rem <= '0;
            r_q   <= w_mag_a;
            r_div <= w_mag_b;
        end else if (r_state == S_RUN) begin
            r_rem <= w_r_nx;
            r_q   <= w_q_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    // Results and done are written on the edge that enters FIN, so done is
    // high for exactly the one cycle spent in FIN. A start that arrives
    // during FIN is dropped because starts are only examined in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            // Skip the iteration. The remainder is the raw
                            // captured dividend, whatever the sign mode.
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= S_FIN;
                        end else begin
                            r_cnt   <= CNT_W'(WIDTH - 1);
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                        r_dbz       <= 1'b0;
                        r_state     <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// ============================================================================
// tb_seq_divider
// ----------------------------------------------------------------------------
// Scoreboard bench for seq_divider (WIDTH=64). Each issued operation pushes
// its expected result and its done edge into a queue. A monitor pops an
// entry on every done pulse and compares the DUT outputs against it.
// ============================================================================
module tb_seq_divider;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far. Edge k leaves cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        nm;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           edge_no;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at edge %0d, expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_quotient"},  quotient,    e.q);
                chk({e.nm, "_remainder"}, remainder,   e.r);
                chk({e.nm, "_dbz"},       W'(div_by_zero), W'(e.dbz));
                chk({e.nm, "_done_edge"}, W'(cyc),     W'(e.edge_no));
                chk({e.nm, "_busy_at_done"}, W'(busy), W'(0));
            end
            chk("done_single_pulse", W'(prev_done), W'(0));
        end
        prev_done = done;
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sg, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, output int e0);
        exp_t e;
        // Called from a negedge: the next rising edge samples start.
        e0 = cyc + 1;
        e.nm = nm; e.q = eq; e.r = er; e.dbz = edbz;
        e.edge_no = (b == '0) ? e0 : e0 + W;
        sb.push_back(e);
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        // Scramble the operands so that only the captured values can matter.
        dividend  = ~a;
        divisor   = ~b;
        is_signed = ~sg;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d results pending, expected 0", nm, sb.size());
            sb.delete();
        end
        @(negedge clk);  // let FIN return to IDLE before the next start
    endtask

    typedef struct {
        string        nm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin
        int   e0;
        vec_t vecs[$];

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy",      W'(busy),        W'(0));
        chk("reset_done",      W'(done),        W'(0));
        chk("reset_quotient",  quotient,        W'(0));
        chk("reset_remainder", remainder,       W'(0));
        chk("reset_dbz",       W'(div_by_zero), W'(0));
        rst = 1'b0;
        @(negedge clk);

        // 100/7 with latency, busy and hold checks
        issue("u100_7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, e0);
        chk("u100_7_busy_cycle1", W'(busy), W'(1));
        while (cyc < e0 + W - 1) @(negedge clk);
        chk("u100_7_busy_last", W'(busy), W'(1));
        chk("u100_7_no_early_done", W'(done), W'(0));
        wait_done("u100_7");
        repeat (10) @(negedge clk);
        chk("u100_7_hold_q", quotient,  64'd14);
        chk("u100_7_hold_r", remainder, 64'd2);

        // Directed vectors, issued back to back
        vecs.push_back('{"umax_1",    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0});
        vecs.push_back('{"umax_max",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0});
        vecs.push_back('{"u5_7",      64'd5, 64'd7, 64'd0, 64'd5, 1'b0});
        vecs.push_back('{"u0_9",      64'd0, 64'd9, 64'd0, 64'd0, 1'b0});
        vecs.push_back('{"umsb_3",    64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0});
        vecs.push_back('{"u1000_3",   64'd1000, 64'd3, 64'd333, 64'd1, 1'b0});
        foreach (vecs[i]) begin
            issue(vecs[i].nm, vecs[i].a, vecs[i].b, 1'b0, vecs[i].q, vecs[i].r, vecs[i].dbz, e0);
            wait_done(vecs[i].nm);
        end

        // Divide by zero: done at once, busy never high
        issue("u1234_0", 64'h1234, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, e0);
        chk("dbz_busy_done_cycle", W'(busy), W'(0));
        @(negedge clk);
        chk("dbz_busy_after", W'(busy), W'(0));
        wait_done("u1234_0");

        // Starts while busy and during done are ignored
        issue("u42_5", 64'd42, 64'd5, 1'b0, 64'd8, 64'd2, 1'b0, e0);
        while (cyc < e0 + 19) @(negedge clk);
        dividend = 64'd9; divisor = 64'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + W) @(negedge clk);
        dividend = 64'd9; divisor = 64'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (80) @(negedge clk);
        chk("ignored_start_busy", W'(busy), W'(0));
        chk("ignored_start_q", quotient, 64'd8);
        chk("ignored_start_pending", W'(sb.size()), W'(0));
        sb.delete();

        // Asynchronous reset in flight
        issue("u1000_3_rst", 64'd1000, 64'd3, 1'b0, 64'd333, 64'd1, 1'b0, e0);
        while (cyc < e0 + 29) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_busy",      W'(busy),        W'(0));
        chk("async_rst_quotient",  quotient,        W'(0));
        chk("async_rst_remainder", remainder,       W'(0));
        chk("async_rst_dbz",       W'(div_by_zero), W'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        issue("u1000_3_fresh", 64'd1000, 64'd3, 1'b0, 64'd333, 64'd1, 1'b0, e0);
        wait_done("u1000_3_fresh");

`ifdef SEQ_DIVIDER_SIGNED_EN
        issue("s_m7_2", -64'sd7, 64'd2, 1'b1, -64'sd3, -64'sd1, 1'b0, e0);
        wait_done("s_m7_2");
        issue("s_7_m2", 64'd7, -64'sd2, 1'b1, -64'sd3, 64'd1, 1'b0, e0);
        wait_done("s_7_m2");
        issue("s_min_m1", 64'h8000_0000_0000_0000, -64'sd1, 1'b1,
              64'h8000_0000_0000_0000, 64'd0, 1'b0, e0);
        wait_done("s_min_m1");
        issue("s_m7_0", -64'sd7, 64'd0, 1'b1, -64'sd1, -64'sd7, 1'b1, e0);
        wait_done("s_m7_0");
`endif

        chk("scoreboard_empty", W'(sb.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
